// File: rtl/cordic_phase_gen.sv
// rtl/cordic_phase_gen.sv - burst phase/amplitude generator feeding a CORDIC rotator
module cordic_phase_gen #(
  parameter int XY_BITS  = 12,
  parameter int PH_BITS  = 32,
  parameter int LEN_BITS = 16,
  parameter int DIV_BITS = 8
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                cfg_load,
  input  logic [PH_BITS-1:0]  ftw_in,
  input  logic [PH_BITS-1:0]  phase_init,
  input  logic [XY_BITS-1:0]  amp_in,
  input  logic [LEN_BITS-1:0] len_in,
  input  logic [DIV_BITS-1:0] div_in,
  input  logic                start,
  input  logic                abort,
  output logic [XY_BITS-1:0]  x_out,
  output logic [XY_BITS-1:0]  y_out,
  output logic [PH_BITS-1:0]  phase_out,
  output logic                valid_out,
  output logic                busy,
  output logic                done,
  output logic [LEN_BITS-1:0] sample_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [PH_BITS-1:0]  ftw_q, ftw_d, ph_init_q, ph_init_d;
  logic [PH_BITS-1:0]  phase_acc_q, phase_acc_d, phase_q, phase_d;
  logic [XY_BITS-1:0]  amp_q, amp_d, x_q, x_d, y_q, y_d;
  logic [LEN_BITS-1:0] len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [DIV_BITS-1:0] div_q, div_d, tick_q, tick_d;
  logic                valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic                fire;

  // The first sample of a burst fires on the first RUN edge regardless of div;
  // afterwards samples are div+1 cycles apart.
  assign fire    = (tick_q == div_q) || (cnt_q == '0);
  assign cnt_inc = cnt_q + LEN_BITS'(1);

  always_comb begin
    state_d     = state_q;
    ftw_d       = ftw_q;
    ph_init_d   = ph_init_q;
    amp_d       = amp_q;
    len_d       = len_q;
    div_d       = div_q;
    phase_acc_d = phase_acc_q;
    phase_d     = phase_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    tick_d      = tick_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    busy_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_load) begin
          ftw_d     = ftw_in;
          ph_init_d = phase_init;
          amp_d     = amp_in;
          len_d     = len_in;
          div_d     = div_in;
        end else if (start) begin
          phase_acc_d = ph_init_q;
          tick_d      = '0;
          cnt_d       = '0;
          if (len_q != '0) begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (fire) begin
          valid_d     = 1'b1;
          phase_d     = phase_acc_q;
          x_d         = amp_q;
          y_d         = '0;
          phase_acc_d = phase_acc_q + ftw_q;
          tick_d      = '0;
          cnt_d       = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            busy_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + DIV_BITS'(1);
          busy_d = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ftw_q       <= '0;
      ph_init_q   <= '0;
      amp_q       <= '0;
      len_q       <= '0;
      div_q       <= '0;
      phase_acc_q <= '0;
      phase_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      tick_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ftw_q       <= ftw_d;
      ph_init_q   <= ph_init_d;
      amp_q       <= amp_d;
      len_q       <= len_d;
      div_q       <= div_d;
      phase_acc_q <= phase_acc_d;
      phase_q     <= phase_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign phase_out  = phase_q;
  assign valid_out  = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_cnt = cnt_q;

endmodule
